// File: rtl/timer_pkg.sv
// Shared definitions for the interval-timer register interface and the
// timer_scroll_master sequencer: register indices, control bits, FSM states.
package timer_pkg;

  // Timer register indices on the Avalon-MM address bus
  localparam logic [2:0] TMR_STATUS   = 3'd0;
  localparam logic [2:0] TMR_CONTROL  = 3'd1;
  localparam logic [2:0] TMR_PERIOD_L = 3'd2;
  localparam logic [2:0] TMR_PERIOD_H = 3'd3;

  // Control register bit positions
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // Control words: run continuously with interrupt, or halt the counter
  localparam logic [15:0] CTRL_RUN  = (16'd1 << CTRL_ITO) | (16'd1 << CTRL_CONT) |
                                      (16'd1 << CTRL_START);
  localparam logic [15:0] CTRL_HALT = (16'd1 << CTRL_STOP);

  // FSM state encoding
  typedef logic [3:0] state_t;
  localparam state_t ST_INIT_PL   = 4'd0;
  localparam state_t ST_INIT_PH   = 4'd1;
  localparam state_t ST_INIT_CTRL = 4'd2;
  localparam state_t ST_IDLE      = 4'd3;
  localparam state_t ST_RD_STAT   = 4'd4;
  localparam state_t ST_RD_WAIT   = 4'd5;
  localparam state_t ST_CLR       = 4'd6;
  localparam state_t ST_STEP      = 4'd7;
  localparam state_t ST_PU_STOP   = 4'd8;
  localparam state_t ST_PU_PL     = 4'd9;
  localparam state_t ST_PU_PH     = 4'd10;
  localparam state_t ST_PU_START  = 4'd11;

endpackage

// File: rtl/scroll_step_wrap.sv
// Modulo step of the scroll offset: one STEP forward or backward, wrapping
// inside [0, SCROLL_MAX]. Arithmetic is done one bit wider than scroll_x so
// the overflow compare and the wrap correction never lose the carry.
module scroll_step_wrap #(
  parameter int unsigned SCROLL_W    = 10,
  parameter int unsigned SCROLL_MAX  = 639,
  parameter int unsigned SCROLL_STEP = 1
) (
  input  logic [SCROLL_W-1:0] x,
  input  logic                dir,
  output logic [SCROLL_W-1:0] x_next
);

  localparam logic [SCROLL_W:0] MAX_E  = (SCROLL_W+1)'(SCROLL_MAX);
  localparam logic [SCROLL_W:0] STEP_E = (SCROLL_W+1)'(SCROLL_STEP);
  localparam logic [SCROLL_W:0] ONE_E  = {{SCROLL_W{1'b0}}, 1'b1};

  logic [SCROLL_W:0] x_e_s;
  logic [SCROLL_W:0] sum_s;
  logic [SCROLL_W:0] wide_s;

  // Next offset: increment wraps past SCROLL_MAX, decrement wraps below zero
  always_comb begin
    x_e_s  = {1'b0, x};
    sum_s  = x_e_s + STEP_E;
    wide_s = x_e_s;
    if (dir == 1'b0) begin
      if (sum_s > MAX_E) begin
        wide_s = sum_s - MAX_E - ONE_E;
      end else begin
        wide_s = sum_s;
      end
    end else begin
      if (x_e_s < STEP_E) begin
        wide_s = x_e_s + MAX_E + ONE_E - STEP_E;
      end else begin
        wide_s = x_e_s - STEP_E;
      end
    end
    x_next = wide_s[SCROLL_W-1:0];
  end

endmodule

// File: rtl/timer_scroll_master.sv
// Avalon-MM master for the 16-bit interval timer. Programs period and control
// after reset, then services every timer IRQ in hardware (status read, clear,
// scroll step). Optional runtime period reload is enabled by defining
// TIMER_SCROLL_PERIOD_UPDATE_EN (adds period_req/period_val/period_ack).
module timer_scroll_master
  import timer_pkg::*;
#(
  parameter logic [31:0] PERIOD      = 32'h0001869F,
  parameter int unsigned SCROLL_W    = 10,
  parameter int unsigned SCROLL_MAX  = 639,
  parameter int unsigned SCROLL_STEP = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [2:0]          avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [15:0]         avm_writedata,
  input  logic [15:0]         avm_readdata,
  input  logic                avm_readdatavalid,
  input  logic                avm_waitrequest,
  input  logic                timer_irq,
  input  logic                scroll_en,
  input  logic                scroll_dir,
  output logic [SCROLL_W-1:0] scroll_x,
  output logic                scroll_tick,
  output logic                init_done,
  output logic [7:0]          spurious_cnt
`ifdef TIMER_SCROLL_PERIOD_UPDATE_EN
  ,
  input  logic                period_req,
  input  logic [31:0]         period_val,
  output logic                period_ack
`endif
);

  state_t              state_r;
  logic                cmd_valid_s;
  logic                cmd_wr_s;
  logic [2:0]          cmd_addr_s;
  logic [15:0]         cmd_data_s;
  state_t              cmd_next_s;
  logic [SCROLL_W-1:0] scroll_next_s;
  logic                unused_readdata_s;

`ifdef TIMER_SCROLL_PERIOD_UPDATE_EN
  logic [31:0]         period_lat_r;
`endif

  // Only the timeout flag of the status word matters here
  assign unused_readdata_s = ^avm_readdata[15:1];

  scroll_step_wrap #(
    .SCROLL_W    (SCROLL_W),
    .SCROLL_MAX  (SCROLL_MAX),
    .SCROLL_STEP (SCROLL_STEP)
  ) u_step (
    .x      (scroll_x),
    .dir    (scroll_dir),
    .x_next (scroll_next_s)
  );

  // Bus command owned by each command state, and where acceptance leads
  always_comb begin
    cmd_valid_s = 1'b0;
    cmd_wr_s    = 1'b0;
    cmd_addr_s  = TMR_STATUS;
    cmd_data_s  = 16'h0000;
    cmd_next_s  = state_r;
    case (state_r)
      ST_INIT_PL: begin
        cmd_valid_s = 1'b1; cmd_wr_s = 1'b1; cmd_addr_s = TMR_PERIOD_L;
        cmd_data_s  = PERIOD[15:0]; cmd_next_s = ST_INIT_PH;
      end
      ST_INIT_PH: begin
        cmd_valid_s = 1'b1; cmd_wr_s = 1'b1; cmd_addr_s = TMR_PERIOD_H;
        cmd_data_s  = PERIOD[31:16]; cmd_next_s = ST_INIT_CTRL;
      end
      ST_INIT_CTRL: begin
        cmd_valid_s = 1'b1; cmd_wr_s = 1'b1; cmd_addr_s = TMR_CONTROL;
        cmd_data_s  = CTRL_RUN; cmd_next_s = ST_IDLE;
      end
      ST_RD_STAT: begin
        cmd_valid_s = 1'b1; cmd_wr_s = 1'b0; cmd_addr_s = TMR_STATUS;
        cmd_data_s  = 16'h0000; cmd_next_s = ST_RD_WAIT;
      end
      ST_CLR: begin
        cmd_valid_s = 1'b1; cmd_wr_s = 1'b1; cmd_addr_s = TMR_STATUS;
        cmd_data_s  = 16'h0000; cmd_next_s = ST_STEP;
      end
`ifdef TIMER_SCROLL_PERIOD_UPDATE_EN
      ST_PU_STOP: begin
        cmd_valid_s = 1'b1; cmd_wr_s = 1'b1; cmd_addr_s = TMR_CONTROL;
        cmd_data_s  = CTRL_HALT; cmd_next_s = ST_PU_PL;
      end
      ST_PU_PL: begin
        cmd_valid_s = 1'b1; cmd_wr_s = 1'b1; cmd_addr_s = TMR_PERIOD_L;
        cmd_data_s  = period_lat_r[15:0]; cmd_next_s = ST_PU_PH;
      end
      ST_PU_PH: begin
        cmd_valid_s = 1'b1; cmd_wr_s = 1'b1; cmd_addr_s = TMR_PERIOD_H;
        cmd_data_s  = period_lat_r[31:16]; cmd_next_s = ST_PU_START;
      end
      ST_PU_START: begin
        cmd_valid_s = 1'b1; cmd_wr_s = 1'b1; cmd_addr_s = TMR_CONTROL;
        cmd_data_s  = CTRL_RUN; cmd_next_s = ST_IDLE;
      end
`endif
      default: begin
        cmd_valid_s = 1'b0;
      end
    endcase
  end

  // Sequencer: issue/hold bus commands, advance on acceptance, service IRQs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_INIT_PL;
      avm_address   <= 3'd0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= 16'h0000;
      scroll_x      <= {SCROLL_W{1'b0}};
      scroll_tick   <= 1'b0;
      init_done     <= 1'b0;
      spurious_cnt  <= 8'd0;
`ifdef TIMER_SCROLL_PERIOD_UPDATE_EN
      period_lat_r  <= 32'd0;
      period_ack    <= 1'b0;
`endif
    end else begin
      scroll_tick <= 1'b0;
`ifdef TIMER_SCROLL_PERIOD_UPDATE_EN
      period_ack  <= 1'b0;
`endif
      if (cmd_valid_s) begin
        if (!(avm_read || avm_write)) begin
          // Launch the command; it is then held until waitrequest drops
          avm_write     <= cmd_wr_s;
          avm_read      <= ~cmd_wr_s;
          avm_address   <= cmd_addr_s;
          avm_writedata <= cmd_data_s;
        end else if (!avm_waitrequest) begin
          avm_write <= 1'b0;
          avm_read  <= 1'b0;
          state_r   <= cmd_next_s;
          if (state_r == ST_INIT_CTRL) begin
            init_done <= 1'b1;
          end
          if (state_r == ST_CLR) begin
            scroll_tick <= 1'b1;
          end
`ifdef TIMER_SCROLL_PERIOD_UPDATE_EN
          if (state_r == ST_PU_START) begin
            period_ack <= 1'b1;
          end
`endif
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
`ifdef TIMER_SCROLL_PERIOD_UPDATE_EN
            if (period_req) begin
              period_lat_r <= period_val;
              state_r      <= ST_PU_STOP;
            end else if (timer_irq) begin
              state_r <= ST_RD_STAT;
            end
`else
            if (timer_irq) begin
              state_r <= ST_RD_STAT;
            end
`endif
          end
          ST_RD_WAIT: begin
            if (avm_readdatavalid) begin
              if (avm_readdata[0]) begin
                state_r <= ST_CLR;
              end else begin
                if (spurious_cnt != 8'hFF) begin
                  spurious_cnt <= spurious_cnt + 8'd1;
                end
                state_r <= ST_IDLE;
              end
            end
          end
          ST_STEP: begin
            if (scroll_en) begin
              scroll_x <= scroll_next_s;
            end
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_INIT_PL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_scroll_master.sv
// Directed bench for timer_scroll_master: a small Avalon slave model logs
// every accepted command, applies programmable waitrequest stalls and
// returns the status word for reads; the main sequence checks init, IRQ
// service, spurious IRQs, scroll wrap and reset mid-transaction.
module tb_timer_scroll_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;
  logic        timer_irq;
  logic        scroll_en;
  logic        scroll_dir;
  logic [9:0]  scroll_x;
  logic        scroll_tick;
  logic        init_done;
  logic [7:0]  spurious_cnt;
`ifdef TIMER_SCROLL_PERIOD_UPDATE_EN
  logic        period_req = 1'b0;
  logic [31:0] period_val = 32'd0;
  logic        period_ack;
`endif

  int          total = 0;
  int          bad   = 0;
  logic [19:0] log_q[$];       // {write, address, writedata} per accepted command
  int          stall_total = 0;
  int          stall_used  = 0;
  logic [15:0] status_val  = 16'h0000;
  int          tick_cnt    = 0;
  logic        pending     = 1'b0;
  logic        stalling    = 1'b0;
  logic [19:0] cap;

  always #5 clk = ~clk;

  timer_scroll_master dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest),
    .timer_irq         (timer_irq),
    .scroll_en         (scroll_en),
    .scroll_dir        (scroll_dir),
    .scroll_x          (scroll_x),
    .scroll_tick       (scroll_tick),
    .init_done         (init_done),
    .spurious_cnt      (spurious_cnt)
`ifdef TIMER_SCROLL_PERIOD_UPDATE_EN
    ,
    .period_req        (period_req),
    .period_val        (period_val),
    .period_ack        (period_ack)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave model, evaluated on the falling edge
  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 16'h0000;
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      if (scroll_tick === 1'b1) tick_cnt++;
      if (reset_n !== 1'b1) begin
        pending         = 1'b0;
        stalling        = 1'b0;
        avm_waitrequest = 1'b0;
      end else begin
        if (pending) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = status_val;
          pending           = 1'b0;
        end
        if (avm_read || avm_write) begin
          check_val("rd_wr_excl", {31'd0, avm_read & avm_write}, 32'd0);
          if (stalling) begin
            check_val("stall_hold", {12'd0, avm_write, avm_address, avm_writedata}, {12'd0, cap});
          end
          if (stall_used < stall_total) begin
            if (!stalling) cap = {avm_write, avm_address, avm_writedata};
            stalling        = 1'b1;
            stall_used++;
            avm_waitrequest = 1'b1;
          end else begin
            stalling        = 1'b0;
            avm_waitrequest = 1'b0;
            log_q.push_back({avm_write, avm_address, avm_write ? avm_writedata : 16'h0000});
            if (avm_read) pending = 1'b1;
          end
        end else begin
          stalling        = 1'b0;
          avm_waitrequest = 1'b0;
        end
      end
    end
  end

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (log_q.size() < n) check_val("log_timeout", log_q.size(), n);
  endtask

  task automatic check_init(input int base);
    wait_log(base + 3, 60);
    repeat (4) @(negedge clk);
    check_val("init_n", log_q.size(), base + 3);
    if (log_q.size() >= base + 3) begin
      check_val("init_pl",   log_q[base],     {12'd0, 1'b1, 3'd2, 16'h869F});
      check_val("init_ph",   log_q[base + 1], {12'd0, 1'b1, 3'd3, 16'h0001});
      check_val("init_ctrl", log_q[base + 2], {12'd0, 1'b1, 3'd1, 16'h0007});
    end
    check_val("init_done", init_done, 1);
  endtask

  task automatic service(input logic [15:0] st, input logic en, input logic dir,
                         input int exp_x, input int exp_spur);
    int base;
    int t0;
    base       = log_q.size();
    t0         = tick_cnt;
    status_val = st;
    scroll_en  = en;
    scroll_dir = dir;
    timer_irq  = 1'b1;
    if (st[0]) wait_log(base + 2, 40);
    else       wait_log(base + 1, 40);
    timer_irq = 1'b0;
    repeat (6) @(negedge clk);
    check_val("svc_n", log_q.size(), st[0] ? base + 2 : base + 1);
    if (log_q.size() > base) check_val("svc_rd", log_q[base], {12'd0, 1'b0, 3'd0, 16'h0000});
    if (st[0] && log_q.size() > base + 1)
      check_val("svc_clr", log_q[base + 1], {12'd0, 1'b1, 3'd0, 16'h0000});
    check_val("svc_tick", tick_cnt - t0, st[0] ? 1 : 0);
    check_val("svc_x", scroll_x, exp_x);
    check_val("svc_spur", spurious_cnt, exp_spur);
  endtask

  initial begin
    int k;
    int base;
    reset_n    = 1'b0;
    timer_irq  = 1'b0;
    scroll_en  = 1'b0;
    scroll_dir = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_ctl",  {avm_read, avm_write, avm_address}, 5'd0);
    check_val("rst_wd",   avm_writedata, 0);
    check_val("rst_x",    scroll_x, 0);
    check_val("rst_tick", scroll_tick, 0);
    check_val("rst_done", init_done, 0);
    check_val("rst_spur", spurious_cnt, 0);
    reset_n = 1'b1;

    // Init sequence with a 3-cycle stall on the period_h write
    wait_log(1, 40);
    stall_total = stall_used + 3;
    wait_log(2, 40);
    check_val("done_early", init_done, 0);
    check_init(0);
    check_val("stall_used", stall_used, 3);

    // IRQ service, spurious IRQ, wrap in both directions, scroll disabled
    service(16'h0003, 1'b1, 1'b0, 1,   0);
    service(16'h0002, 1'b1, 1'b0, 1,   1);
    service(16'h0001, 1'b1, 1'b1, 0,   1);
    service(16'h0001, 1'b1, 1'b1, 639, 1);
    service(16'h0003, 1'b1, 1'b0, 0,   1);
    service(16'h0001, 1'b0, 1'b1, 0,   1);
    service(16'h0001, 1'b1, 1'b1, 639, 1);
    service(16'h0001, 1'b0, 1'b0, 639, 1);

    // Reset while the status read is stalled on the bus
    stall_total = stall_used + 30;
    status_val  = 16'h0001;
    timer_irq   = 1'b1;
    k = 0;
    while (avm_read !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (avm_read !== 1'b1) check_val("rd_timeout", {31'd0, avm_read}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("mrst_ctl",  {avm_read, avm_write, avm_address}, 5'd0);
    check_val("mrst_x",    scroll_x, 0);
    check_val("mrst_done", init_done, 0);
    check_val("mrst_spur", spurious_cnt, 0);
    timer_irq   = 1'b0;
    stall_total = stall_used;
    repeat (2) @(negedge clk);
    base    = log_q.size();
    reset_n = 1'b1;
    check_init(base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
